// File: rtl/io_xbar_input_port.sv
// Crossbar input port: credit-returning receive FIFO with header decode and packet framing.
// Optional overflow error detection is built when IO_XBAR_INPUT_ERR_CHK_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef CHIP_ID_WIDTH
`define CHIP_ID_WIDTH 14
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef PAYLOAD_LEN
`define PAYLOAD_LEN 8
`endif

module io_xbar_input_port #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [`DATA_WIDTH-1:0] data_in,
    input  logic                   valid_in,
    output logic                   yummy_out,
    output logic [`DATA_WIDTH-1:0] data_out,
    output logic                   valid_out,
    output logic                   route_req_0_out,
    output logic                   route_req_1_out,
    output logic                   route_req_2_out,
    output logic                   route_req_3_out,
    output logic                   route_req_4_out,
    output logic                   route_req_5_out,
    output logic                   route_req_6_out,
    output logic                   route_req_7_out,
    output logic                   tail_out,
    input  logic                   thanks_0_in,
    input  logic                   thanks_1_in,
    input  logic                   thanks_2_in,
    input  logic                   thanks_3_in,
    input  logic                   thanks_4_in,
    input  logic                   thanks_5_in,
    input  logic                   thanks_6_in,
    input  logic                   thanks_7_in,
    output logic                   overflow_err_out
);
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int LEN_MSB  = `DATA_WIDTH - `CHIP_ID_WIDTH - 2 * `XY_WIDTH - 4;
    localparam int DEST_LSB = `DATA_WIDTH - `CHIP_ID_WIDTH;

    typedef enum logic [0:0] {ST_HEADER = 1'b0, ST_BODY = 1'b1} state_e;

    logic [`DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [`DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    state_e                 state_q, state_d;
    logic [7:0]             rem_q, rem_d;
    logic                   yummy_q, yummy_d;
    logic                   full_s, pop_s, push_s, thanks_any_s;
    logic [`PAYLOAD_LEN-1:0] head_len_s;
    logic [2:0]             head_dest_s;
    logic [7:0]             route_vec_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign thanks_any_s = |{thanks_7_in, thanks_6_in, thanks_5_in, thanks_4_in,
                            thanks_3_in, thanks_2_in, thanks_1_in, thanks_0_in};
    assign valid_out    = (count_q != {CNT_W{1'b0}});
    assign full_s       = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_s        = valid_out & thanks_any_s;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign push_s       = valid_in & (~full_s | pop_s);
    assign data_out     = mem_q[rd_ptr_q];
    assign head_len_s   = data_out[LEN_MSB -: `PAYLOAD_LEN];
    assign head_dest_s  = data_out[DEST_LSB + 2 : DEST_LSB];
    assign yummy_out    = yummy_q;

    // FIFO storage, pointers and occupancy next-state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Packet framing FSM; only pops move it.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        yummy_d = pop_s;
        if (pop_s) begin
            case (state_q)
                ST_HEADER: begin
                    if (head_len_s != {`PAYLOAD_LEN{1'b0}}) begin
                        rem_d   = 8'(head_len_s);
                        state_d = ST_BODY;
                    end else begin
                        state_d = ST_HEADER;
                    end
                end
                ST_BODY: begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = ST_HEADER;
                    end else begin
                        state_d = ST_BODY;
                    end
                end
                default: state_d = ST_HEADER;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Route request and tail decode of the head flit.
    always_comb begin
        route_vec_s = 8'h00;
        tail_out    = 1'b0;
        if (valid_out && (state_q == ST_HEADER)) begin
            route_vec_s = 8'h01 << head_dest_s;
            tail_out    = (head_len_s == {`PAYLOAD_LEN{1'b0}});
        end else if (valid_out) begin
            tail_out = (rem_q == 8'd1);
        end else begin
            route_vec_s = 8'h00;
        end
    end

    assign {route_req_7_out, route_req_6_out, route_req_5_out, route_req_4_out,
            route_req_3_out, route_req_2_out, route_req_1_out, route_req_0_out} = route_vec_s;

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            state_q  <= ST_HEADER;
            rem_q    <= 8'd0;
            yummy_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            rem_q    <= rem_d;
            yummy_q  <= yummy_d;
        end
    end

    // Flit storage needs no reset; occupancy qualifies every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef IO_XBAR_INPUT_ERR_CHK_EN
    logic err_q, err_d, drop_s;
    assign drop_s           = valid_in & full_s & ~pop_s;
    assign err_d            = err_q | drop_s;
    assign overflow_err_out = err_q;

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign overflow_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_io_xbar_input_port.sv
// Randomized bench for io_xbar_input_port against a queue-based packet model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef CHIP_ID_WIDTH
`define CHIP_ID_WIDTH 14
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef PAYLOAD_LEN
`define PAYLOAD_LEN 8
`endif

module tb_io_xbar_input_port;
    localparam int DEPTH    = 4;
    localparam int LEN_MSB  = `DATA_WIDTH - `CHIP_ID_WIDTH - 2 * `XY_WIDTH - 4;
    localparam int DEST_LSB = `DATA_WIDTH - `CHIP_ID_WIDTH;
`ifdef IO_XBAR_INPUT_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [`DATA_WIDTH-1:0] data_in = '0;
    logic valid_in = 1'b0;
    logic [7:0] th_vec = 8'h00;
    logic yummy_out, valid_out, tail_out, overflow_err_out;
    logic [`DATA_WIDTH-1:0] data_out;
    logic [7:0] route_vec;

    int total = 0;
    int bad = 0;

    logic [`DATA_WIDTH-1:0] q[$];
    logic [`DATA_WIDTH-1:0] src[$];
    int pkt_rem = 0;
    bit yum_exp = 1'b0;
    bit err_exp = 1'b0;
    int pops = 0;
    int yums = 0;

    io_xbar_input_port #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .yummy_out(yummy_out), .data_out(data_out), .valid_out(valid_out),
        .route_req_0_out(route_vec[0]), .route_req_1_out(route_vec[1]),
        .route_req_2_out(route_vec[2]), .route_req_3_out(route_vec[3]),
        .route_req_4_out(route_vec[4]), .route_req_5_out(route_vec[5]),
        .route_req_6_out(route_vec[6]), .route_req_7_out(route_vec[7]),
        .tail_out(tail_out),
        .thanks_0_in(th_vec[0]), .thanks_1_in(th_vec[1]), .thanks_2_in(th_vec[2]),
        .thanks_3_in(th_vec[3]), .thanks_4_in(th_vec[4]), .thanks_5_in(th_vec[5]),
        .thanks_6_in(th_vec[6]), .thanks_7_in(th_vec[7]),
        .overflow_err_out(overflow_err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [`DATA_WIDTH-1:0] obs,
                       input logic [`DATA_WIDTH-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int hlen(input logic [`DATA_WIDTH-1:0] f);
        return int'(f[LEN_MSB -: `PAYLOAD_LEN]);
    endfunction

    function automatic int hdest(input logic [`DATA_WIDTH-1:0] f);
        return int'(f[DEST_LSB + 2 : DEST_LSB]);
    endfunction

    function automatic logic [`DATA_WIDTH-1:0] mk_hdr(input int len, input int dest);
        logic [`DATA_WIDTH-1:0] f;
        f = {$urandom, $urandom};
        f[LEN_MSB -: `PAYLOAD_LEN] = `PAYLOAD_LEN'(len);
        f[DEST_LSB + 2 : DEST_LSB] = 3'(dest);
        return f;
    endfunction

    function automatic logic [7:0] exp_route();
        if (q.size() == 0 || pkt_rem != 0) return 8'h00;
        return 8'h01 << hdest(q[0]);
    endfunction

    function automatic logic exp_tail();
        if (q.size() == 0) return 1'b0;
        if (pkt_rem == 0) return (hlen(q[0]) == 0);
        return (pkt_rem == 1);
    endfunction

    // One clock: compare outputs, drive inputs, then advance the model at the edge.
    task automatic step(input bit vin, input logic [`DATA_WIDTH-1:0] din,
                        input logic [7:0] th, input bit rst);
        bit pop;
        @(negedge clk);
        chk("valid", valid_out, q.size() > 0);
        if (q.size() > 0) chk("data", data_out, q[0]);
        chk("route", route_vec, exp_route());
        chk("tail", tail_out, exp_tail());
        chk("yummy", yummy_out, yum_exp);
        chk("err", overflow_err_out, err_exp);
        if (yummy_out) yums++;
        reset = rst; valid_in = vin; data_in = din; th_vec = th;
        @(posedge clk);
        if (rst) begin
            q.delete(); pkt_rem = 0; yum_exp = 1'b0; err_exp = 1'b0;
        end else begin
            pop = (q.size() > 0) && (th != 8'h00);
            yum_exp = pop;
            if (pop) begin
                pops++;
                if (pkt_rem == 0) pkt_rem = hlen(q[0]);
                else pkt_rem--;
                void'(q.pop_front());
            end
            if (vin) begin
                if (q.size() < DEPTH) q.push_back(din);
                else if (ERR_EN) err_exp = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [`DATA_WIDTH-1:0] f;
        logic [7:0] th;
        bit vin;
        int cyc;
        repeat (2) @(posedge clk);
        step(1'b0, '0, 8'h00, 1'b1);
        idle(1);

        // Single header, length 0, dest 5.
        step(1'b1, mk_hdr(0, 5), 8'h00, 1'b0);
        #1;
        chk("r029_valid", valid_out, 1'b1);
        chk("r029_route5", route_vec, 8'h20);
        chk("r029_tail", tail_out, 1'b1);
        step(1'b0, '0, 8'h20, 1'b0);
        #1;
        chk("r029_yummy", yummy_out, 1'b1);
        chk("r029_empty", valid_out, 1'b0);
        step(1'b0, '0, 8'h04, 1'b0);   // thanks while empty ignored
        idle(1);

        // Header length 2 to dest 0 with two body flits.
        step(1'b1, mk_hdr(2, 0), 8'h00, 1'b0);
        step(1'b1, {$urandom, $urandom}, 8'h01, 1'b0);
        step(1'b1, {$urandom, $urandom}, 8'h01, 1'b0);
        step(1'b0, '0, 8'h01, 1'b0);
        idle(2);

        // Fill, push+pop at full, then overflow.
        for (int i = 0; i < DEPTH; i++) step(1'b1, mk_hdr(0, i), 8'h00, 1'b0);
        step(1'b1, mk_hdr(0, 6), 8'h40, 1'b0);
        #1;
        chk("r031_noerr", overflow_err_out, 1'b0);
        step(1'b1, mk_hdr(0, 7), 8'h00, 1'b0);
        #1;
        chk("r032_err", overflow_err_out, ERR_EN);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 8'h02, 1'b0);
        idle(2);
        step(1'b0, '0, 8'h00, 1'b1);
        idle(1);

        // Reset mid-packet, with a pop coinciding with reset.
        step(1'b1, mk_hdr(3, 2), 8'h00, 1'b0);
        step(1'b1, {$urandom, $urandom}, 8'h00, 1'b0);
        step(1'b1, {$urandom, $urandom}, 8'h04, 1'b0);
        step(1'b0, '0, 8'h04, 1'b1);
        step(1'b0, '0, 8'h00, 1'b0);
        #1;
        chk("r033_noyummy", yummy_out, 1'b0);
        step(1'b1, mk_hdr(1, 3), 8'h00, 1'b0);
        #1;
        chk("r033_hdr_route", route_vec, 8'h08);
        step(1'b1, {$urandom, $urandom}, 8'h08, 1'b0);
        step(1'b0, '0, 8'h08, 1'b0);
        idle(2);

        // Random packets with stalls and back-to-back traffic.
        pops = 0; yums = 0;
        for (int p = 0; p < 10; p++) begin
            int len;
            len = $urandom_range(0, 5);
            src.push_back(mk_hdr(len, $urandom_range(0, 7)));
            for (int b = 0; b < len; b++) src.push_back({$urandom, $urandom});
        end
        cyc = 0;
        while ((src.size() > 0 || q.size() > 0) && cyc < 2000) begin
            th = ($urandom_range(0, 2) != 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            vin = (src.size() > 0) && ((q.size() < DEPTH) || (th != 8'h00))
                  && ($urandom_range(0, 3) != 0);
            f = vin ? src[0] : '0;
            step(vin, f, th, 1'b0);
            if (vin) void'(src.pop_front());
            cyc++;
        end
        chk("r034_drained", (cyc < 2000), 1'b1);
        idle(2);
        chk("r034_yummy_cnt", yums, pops);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
